priority_target_scheduler: RTL and testbench
============================================

Name: priority_target_scheduler

Overview:
- Parametrised successor to the two-point priority-zone checker in the extinguisher targeting path.
- Captures a frame of up to NUM_PTS detected hot-spot coordinates plus a rectangular priority zone.
- Streams the valid points to the nozzle controller one at a time: all in-zone points first, in index order, then all out-of-zone points, in index order.
- Uses a valid/ready output handshake so the nozzle can stall between targets.

Parameters:
- COORD_W, 4, bit width of each x/y coordinate (unsigned).
- NUM_PTS, 4, number of point slots per frame (>=2).
- IDX_W, $clog2(NUM_PTS), width of point index and counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  frame available.
- in_ready  out  1  block can accept a frame.
- in_mask  in  NUM_PTS  bit i=1: slot i holds a real point.
- in_pts_x  in  NUM_PTS*COORD_W  packed x coords, slot i at bits [i*COORD_W +: COORD_W].
- in_pts_y  in  NUM_PTS*COORD_W  packed y coords, same packing.
- zone_start_x, zone_start_y, zone_end_x, zone_end_y  in  COORD_W each  inclusive zone bounds.
- out_valid  out  1  target presented.
- out_ready  in  1  consumer accepts the target.
- out_x, out_y  out  COORD_W each  target coordinates.
- out_idx  out  IDX_W  source slot of the target.
- out_in_zone  out  1  target lies inside the zone.
- out_last  out  1  final target of the frame.
- frame_done  out  1  one-cycle pulse when the frame is finished.

Behaviour:
- Reset (reset_n=0, async):
  - FSM goes to IDLE.
  - All outputs are 0 except in_ready=1.
  - Captured frame registers and counters are cleared.
  - Reset mid-frame discards the frame; no frame_done pulse is issued.
- Zone test: unsigned, inclusive, evaluated on captured values as start_x<=x<=end_x AND start_y<=y<=end_y. If start>end on either axis, the zone is empty and every point is out-of-zone.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: register mask, points and bounds; set remaining=popcount(in_mask); ptr=0.
  - If the mask is zero, go to FIN. Otherwise go to PASS_IN.
  - in_ready=0 in every state other than IDLE. New frames are not accepted while a frame is being streamed.
- PASS_IN: examines slot ptr each cycle.
  - Slot qualifies if mask[ptr]=1 and it is in-zone. A qualifying slot drives out_valid=1 with out_x/out_y/out_idx and out_in_zone=1, held stable until out_ready=1.
  - On handshake: remaining--, ptr++.
  - A non-qualifying slot advances ptr in one cycle with out_valid=0.
  - When ptr wraps past NUM_PTS-1: go to PASS_OUT with ptr=0.
- PASS_OUT: same as PASS_IN, but a slot qualifies if mask[ptr]=1 and it is not in-zone; out_in_zone=0.
  - After the last slot, go to FIN.
- Early exit: when the handshake occurs with remaining==1, go directly to FIN. Remaining slots are not scanned.
- out_last = out_valid && remaining==1. It is combinational from registered state.
- FIN: frame_done=1 for exactly one cycle, then IDLE. in_ready rises on the IDLE cycle.
- Output stability: while out_valid=1 and out_ready=0, all out_* signals stay constant. out_ready while out_valid=0 is ignored.
- Latency:
  - First target is presented 1 cycle after frame capture if slot 0 qualifies in PASS_IN.
  - Worst case is 2*NUM_PTS cycles plus consumer stalls, plus 1 FIN cycle.
- Input changes after capture have no effect on the frame in flight.

Test Plan:
- NUM_PTS=4, COORD_W=4. Zone (2,2)-(5,5); pts (0,0),(3,3),(9,1),(4,5); mask=1111; out_ready=1.
  -> Outputs idx 1,3 with in_zone=1, then idx 0,2 with in_zone=0. out_last only on idx 2. frame_done 1 cycle later. in_ready returns.
- Same frame, out_ready held 0 for 5 cycles at the first target.
  -> idx1 (3,3) is held stable for 5 cycles. There is no skip or duplicate, and the remaining order is unchanged.
- Mask=0000.
  -> No out_valid. frame_done pulses 1 cycle after capture, then IDLE.
- Inverted zone start=(6,6), end=(1,1); mask=0101.
  -> idx 0, then idx 2, both with in_zone=0. out_last on idx 2.
- Boundary: zone (3,3)-(3,3), point (3,3) in slot 3, others masked off.
  -> A single target idx 3 with in_zone=1 and out_last=1. Early exit: PASS_OUT is not entered.
- reset_n pulled low while a target is stalled.
  -> out_valid=0 and in_ready=1 immediately (async). No frame_done. The next frame is processed normally.

Source files
------------

// File: rtl/priority_target_scheduler_if.sv
// Frame-in / target-out bundle for the priority target scheduler.
// slave = scheduler view, master = frame source and nozzle consumer view.
interface priority_target_scheduler_if #(
  parameter int COORD_W = 4,
  parameter int NUM_PTS = 4,
  parameter int IDX_W   = $clog2(NUM_PTS)
);
  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_PTS-1:0]         in_mask;
  logic [NUM_PTS*COORD_W-1:0] in_pts_x;
  logic [NUM_PTS*COORD_W-1:0] in_pts_y;
  logic [COORD_W-1:0]         zone_start_x;
  logic [COORD_W-1:0]         zone_start_y;
  logic [COORD_W-1:0]         zone_end_x;
  logic [COORD_W-1:0]         zone_end_y;
  logic                       out_valid;
  logic                       out_ready;
  logic [COORD_W-1:0]         out_x;
  logic [COORD_W-1:0]         out_y;
  logic [IDX_W-1:0]           out_idx;
  logic                       out_in_zone;
  logic                       out_last;
  logic                       frame_done;

  modport slave (
    input  in_valid, in_mask, in_pts_x, in_pts_y,
    input  zone_start_x, zone_start_y, zone_end_x, zone_end_y,
    input  out_ready,
    output in_ready, out_valid, out_x, out_y, out_idx, out_in_zone, out_last,
    output frame_done
  );

  modport master (
    output in_valid, in_mask, in_pts_x, in_pts_y,
    output zone_start_x, zone_start_y, zone_end_x, zone_end_y,
    output out_ready,
    input  in_ready, out_valid, out_x, out_y, out_idx, out_in_zone, out_last,
    input  frame_done
  );
endinterface

// File: rtl/priority_target_scheduler.sv
// Captures a frame of hot-spot points and streams in-zone points first,
// then out-of-zone points, each pass in slot order, over a valid/ready port.
module priority_target_scheduler #(
  parameter int COORD_W = 4,
  parameter int NUM_PTS = 4,
  parameter int IDX_W   = $clog2(NUM_PTS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  priority_target_scheduler_if.slave   bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PASS_IN  = 2'd1;
  localparam logic [1:0] S_PASS_OUT = 2'd2;
  localparam logic [1:0] S_FIN      = 2'd3;

  // remaining must hold NUM_PTS itself, hence one bit wider than an index
  localparam int              CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NUM_PTS - 1);

  logic [1:0]                 state_q, state_d;
  logic [NUM_PTS-1:0]         mask_q, mask_d;
  logic [NUM_PTS*COORD_W-1:0] pts_x_q, pts_x_d;
  logic [NUM_PTS*COORD_W-1:0] pts_y_q, pts_y_d;
  logic [COORD_W-1:0]         zsx_q, zsx_d;
  logic [COORD_W-1:0]         zsy_q, zsy_d;
  logic [COORD_W-1:0]         zex_q, zex_d;
  logic [COORD_W-1:0]         zey_q, zey_d;
  logic [CNT_W-1:0]           remaining_q, remaining_d;
  logic [IDX_W-1:0]           ptr_q, ptr_d;

  logic [COORD_W-1:0] slot_x [NUM_PTS];
  logic [COORD_W-1:0] slot_y [NUM_PTS];
  logic [NUM_PTS-1:0] slot_in_zone;

  // An inverted bound on either axis makes the inclusive test false for all points
  for (genvar gi = 0; gi < NUM_PTS; gi++) begin : g_slot
    assign slot_x[gi]       = pts_x_q[gi*COORD_W +: COORD_W];
    assign slot_y[gi]       = pts_y_q[gi*COORD_W +: COORD_W];
    assign slot_in_zone[gi] = (zsx_q <= slot_x[gi]) && (slot_x[gi] <= zex_q) &&
                              (zsy_q <= slot_y[gi]) && (slot_y[gi] <= zey_q);
  end

  logic passing;
  logic cur_in_zone;
  logic qualify;
  logic handshake;
  logic [CNT_W-1:0] pop_cnt;

  assign passing     = (state_q == S_PASS_IN) || (state_q == S_PASS_OUT);
  assign cur_in_zone = slot_in_zone[ptr_q];
  assign qualify     = passing && mask_q[ptr_q] && (cur_in_zone == (state_q == S_PASS_IN));
  assign handshake   = qualify && bus.out_ready;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < NUM_PTS; i++) begin
      pop_cnt = pop_cnt + CNT_W'(bus.in_mask[i]);
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = qualify;
  assign bus.out_x       = qualify ? slot_x[ptr_q] : '0;
  assign bus.out_y       = qualify ? slot_y[ptr_q] : '0;
  assign bus.out_idx     = qualify ? ptr_q : '0;
  assign bus.out_in_zone = qualify && cur_in_zone;
  assign bus.out_last    = qualify && (remaining_q == CNT_ONE);
  assign bus.frame_done  = (state_q == S_FIN);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    pts_x_d     = pts_x_q;
    pts_y_d     = pts_y_q;
    zsx_d       = zsx_q;
    zsy_d       = zsy_q;
    zex_d       = zex_q;
    zey_d       = zey_q;
    remaining_d = remaining_q;
    ptr_d       = ptr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mask_d      = bus.in_mask;
          pts_x_d     = bus.in_pts_x;
          pts_y_d     = bus.in_pts_y;
          zsx_d       = bus.zone_start_x;
          zsy_d       = bus.zone_start_y;
          zex_d       = bus.zone_end_x;
          zey_d       = bus.zone_end_y;
          remaining_d = pop_cnt;
          ptr_d       = '0;
          state_d     = (|bus.in_mask) ? S_PASS_IN : S_FIN;
        end
      end
      S_PASS_IN, S_PASS_OUT: begin
        if (handshake && (remaining_q == CNT_ONE)) begin
          // Last real point delivered: skip scanning whatever slots are left
          remaining_d = '0;
          state_d     = S_FIN;
        end else if (handshake || !qualify) begin
          if (handshake) begin
            remaining_d = remaining_q - CNT_ONE;
          end
          if (ptr_q == LAST_PTR) begin
            ptr_d   = '0;
            state_d = (state_q == S_PASS_IN) ? S_PASS_OUT : S_FIN;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      pts_x_q     <= '0;
      pts_y_q     <= '0;
      zsx_q       <= '0;
      zsy_q       <= '0;
      zex_q       <= '0;
      zey_q       <= '0;
      remaining_q <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      pts_x_q     <= pts_x_d;
      pts_y_q     <= pts_y_d;
      zsx_q       <= zsx_d;
      zsy_q       <= zsy_d;
      zex_q       <= zex_d;
      zey_q       <= zey_d;
      remaining_q <= remaining_d;
      ptr_q       <= ptr_d;
    end
  end

endmodule

// File: tb/tb_priority_target_scheduler.sv
// Scoreboard bench: frames are turned into an expected target list by a
// sort-by-zone model; a negedge monitor pops and compares on every handshake.
module tb_priority_target_scheduler;

  localparam int CW = 4;
  localparam int NP = 4;
  localparam int IW = $clog2(NP);

  logic clk;
  logic reset_n;

  priority_target_scheduler_if #(.COORD_W(CW), .NUM_PTS(NP), .IDX_W(IW)) bus ();

  priority_target_scheduler #(.COORD_W(CW), .NUM_PTS(NP), .IDX_W(IW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int idx;
    int x;
    int y;
    bit iz;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   exp_done;
  int   total;
  int   bad;
  int   rdy_mode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endfunction

  // Consumer: random backpressure, always-ready, or stalled
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      bus.out_ready = ($urandom_range(0, 3) != 0);
      else if (rdy_mode == 1) bus.out_ready = 1'b1;
      else                    bus.out_ready = 1'b0;
    end
  end

  // Monitor
  initial begin
    bit   have_prev;
    bit   done_next;
    int   p_idx, p_x, p_y;
    bit   p_iz, p_last;
    exp_t e;
    have_prev = 0;
    done_next = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        have_prev = 0;
        done_next = 0;
      end else begin
        if (have_prev) begin
          check("stall_valid", bus.out_valid, 1);
          check("stall_idx", bus.out_idx, p_idx);
          check("stall_x", bus.out_x, p_x);
          check("stall_y", bus.out_y, p_y);
          check("stall_iz", bus.out_in_zone, p_iz);
          check("stall_last", bus.out_last, p_last);
        end
        if (done_next) begin
          check("done_after_last", bus.frame_done, 1);
          done_next = 0;
        end
        if (bus.frame_done) begin
          check("done_expected", (exp_done != 0), 1);
          check("done_queue_empty", exp_q.size(), 0);
          if (exp_done > 0) exp_done--;
        end
        if (bus.out_valid) check("in_ready_busy", bus.in_ready, 0);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_target", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("idx", bus.out_idx, e.idx);
            check("x", bus.out_x, e.x);
            check("y", bus.out_y, e.y);
            check("in_zone", bus.out_in_zone, e.iz);
            check("last", bus.out_last, e.last);
            $display("target idx=%0d x=%0d y=%0d iz=%0d last=%0d", bus.out_idx, bus.out_x,
                     bus.out_y, bus.out_in_zone, bus.out_last);
            if (e.last) done_next = 1;
          end
        end
        have_prev = bus.out_valid && !bus.out_ready;
        p_idx  = bus.out_idx;
        p_x    = bus.out_x;
        p_y    = bus.out_y;
        p_iz   = bus.out_in_zone;
        p_last = bus.out_last;
      end
    end
  end

  task automatic send_frame(input logic [NP-1:0] m, input logic [NP*CW-1:0] xs,
                            input logic [NP*CW-1:0] ys, input logic [CW-1:0] sx,
                            input logic [CW-1:0] sy, input logic [CW-1:0] ex,
                            input logic [CW-1:0] ey);
    exp_t        tmp[$];
    exp_t        e;
    bit          ok;
    bit          iz;
    logic [CW-1:0] x, y;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    check("in_ready_wait", ok, 1);
    // Reference: in-zone points in slot order, then out-of-zone points
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NP; i++) begin
        x  = xs[i*CW +: CW];
        y  = ys[i*CW +: CW];
        iz = (sx <= x) && (x <= ex) && (sy <= y) && (y <= ey);
        if (m[i] && (iz == (p == 0))) begin
          e.idx = i; e.x = x; e.y = y; e.iz = iz; e.last = 0;
          tmp.push_back(e);
        end
      end
    end
    if (tmp.size() > 0) tmp[tmp.size()-1].last = 1;
    $display("frame mask=%b xs=%h ys=%h zone=(%0d,%0d)-(%0d,%0d) targets=%0d",
             m, xs, ys, sx, sy, ex, ey, tmp.size());
    @(posedge clk);
    #1;
    bus.in_valid     = 1'b1;
    bus.in_mask      = m;
    bus.in_pts_x     = xs;
    bus.in_pts_y     = ys;
    bus.zone_start_x = sx;
    bus.zone_start_y = sy;
    bus.zone_end_x   = ex;
    bus.zone_end_y   = ey;
    foreach (tmp[i]) exp_q.push_back(tmp[i]);
    exp_done++;
    @(posedge clk);
    #1;
    bus.in_valid     = 1'b0;
    bus.in_mask      = NP'($urandom);
    bus.in_pts_x     = (NP*CW)'($urandom);
    bus.in_pts_y     = (NP*CW)'($urandom);
    bus.zone_start_x = CW'($urandom);
    bus.zone_end_x   = CW'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      if (exp_done == 0 && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic wait_out_valid(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [15:0] T1_X = 16'h4930;
  localparam logic [15:0] T1_Y = 16'h5130;

  initial begin
    total    = 0;
    bad      = 0;
    exp_done = 0;
    rdy_mode = 1;
    reset_n  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_mask  = '0;
    bus.in_pts_x = '0;
    bus.in_pts_y = '0;
    bus.zone_start_x = '0;
    bus.zone_start_y = '0;
    bus.zone_end_x   = '0;
    bus.zone_end_y   = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_x", bus.out_x, 0);
    reset_n = 1'b1;

    // Basic frame, consumer always ready
    send_frame(4'b1111, T1_X, T1_Y, 4'd2, 4'd2, 4'd5, 4'd5);
    wait_done("t1_done");

    // Stall at the first target for 5 cycles
    rdy_mode = 2;
    send_frame(4'b1111, T1_X, T1_Y, 4'd2, 4'd2, 4'd5, 4'd5);
    wait_out_valid("t2_first_valid");
    for (int k = 0; k < 5; k++) begin
      check("t2_hold_idx", bus.out_idx, 1);
      check("t2_hold_x", bus.out_x, 3);
      @(negedge clk);
    end
    rdy_mode = 1;
    wait_done("t2_done");

    // Empty mask: frame_done right after capture
    send_frame(4'b0000, T1_X, T1_Y, 4'd2, 4'd2, 4'd5, 4'd5);
    @(negedge clk);
    check("t3_done_pulse", bus.frame_done, 1);
    check("t3_no_valid", bus.out_valid, 0);
    wait_done("t3_done");
    @(negedge clk);
    check("t3_idle_ready", bus.in_ready, 1);

    // Inverted zone
    send_frame(4'b0101, T1_X, T1_Y, 4'd6, 4'd6, 4'd1, 4'd1);
    wait_done("t4_done");

    // Single-point zone, only slot 3 real
    send_frame(4'b1000, 16'h3333, 16'h3333, 4'd3, 4'd3, 4'd3, 4'd3);
    wait_done("t5_done");

    // Async reset while a target is stalled
    rdy_mode = 2;
    send_frame(4'b1111, T1_X, T1_Y, 4'd2, 4'd2, 4'd5, 4'd5);
    wait_out_valid("t6_first_valid");
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_rst_out_valid", bus.out_valid, 0);
    check("t6_rst_in_ready", bus.in_ready, 1);
    check("t6_rst_frame_done", bus.frame_done, 0);
    exp_q.delete();
    exp_done = 0;
    repeat (3) @(posedge clk);
    #2;
    reset_n  = 1'b1;
    rdy_mode = 1;
    send_frame(4'b1111, T1_X, T1_Y, 4'd2, 4'd2, 4'd5, 4'd5);
    wait_done("t6_after_reset_done");

    // Random frames with random backpressure
    rdy_mode = 0;
    for (int f = 0; f < 30; f++) begin
      send_frame(NP'($urandom), (NP*CW)'($urandom), (NP*CW)'($urandom),
                 CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom));
      wait_done("rand_done");
    end

    repeat (3) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
